// File: rtl/pll_phase_ctrl.sv
// ---------------------------------------------------------------------------
// PllPhaseCtrl (module pll_phase_ctrl)
//
// Purpose:
//   Sequences dynamic phase reconfiguration of a PLL. A request (updatepll)
//   carries an absolute phase step count and an input clock select. The
//   block walks the PLL phase one step at a time toward the target using the
//   phasestep/phaseupdown/phasedone handshake, which is timed against a
//   free-running scanclk. It can optionally switch the PLL input clock first.
//   One further request can be queued while busy, and the most recent one
//   wins.
//
// Build option:
//   PLL_CLKSWITCH_EN - when defined, a request whose clock source differs
//                      from cur_src pulses clkswitch for CLKSWITCH_CYCLES clk
//                      cycles and toggles cur_src. When undefined, clkswitch
//                      is tied low, pll_clk_src is ignored and cur_src
//                      stays 0.
//
// Parameters:
//   SCANCLK_DIV      clk cycles per scanclk half-period (min 2)
//   CLKSWITCH_CYCLES clk cycles clkswitch is held high
//   DONE_TIMEOUT     clk cycles allowed for each phasedone wait
//
// Ports:
//   clk                in  system clock
//   rst_n              in  asynchronous active-low reset
//   updatepll          in  one-cycle request strobe
//   pll_clk_src        in  requested PLL input clock (0=inclk0, 1=inclk1)
//   pll_clk_phase      in  requested absolute phase step count
//   phasedone          in  PLL phase-shift done, high = idle
//   scanclk            out PLL scan clock
//   phasecounterselect out counter select, always 000 (all counters)
//   phaseupdown        out step direction, 1 = up
//   phasestep          out PLL phase step request
//   clkswitch          out PLL clock switch request
//   busy               out request in progress or pending
//   cur_phase          out phase step count currently applied
//   cur_src            out input clock currently selected
//   timeout_err        out sticky phasedone timeout flag
// ---------------------------------------------------------------------------
module pll_phase_ctrl #(
  parameter int SCANCLK_DIV      = 4,
  parameter int CLKSWITCH_CYCLES = 8,
  parameter int DONE_TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       updatepll,
  input  logic       pll_clk_src,
  input  logic [7:0] pll_clk_phase,
  input  logic       phasedone,
  output logic       scanclk,
  output logic [2:0] phasecounterselect,
  output logic       phaseupdown,
  output logic       phasestep,
  output logic       clkswitch,
  output logic       busy,
  output logic [7:0] cur_phase,
  output logic       cur_src,
  output logic       timeout_err
);

  localparam int DivW  = (SCANCLK_DIV > 1) ? $clog2(SCANCLK_DIV) : 1;
  localparam int SwW   = $clog2(CLKSWITCH_CYCLES + 1);
  localparam int WaitW = $clog2(DONE_TIMEOUT + 1);

  localparam logic [DivW-1:0]  DivLast  = DivW'(SCANCLK_DIV - 1);
  localparam logic [SwW-1:0]   SwLast   = SwW'(CLKSWITCH_CYCLES - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(DONE_TIMEOUT - 1);

`ifdef PLL_CLKSWITCH_EN
  localparam bit SwitchEn = 1'b1;
`else
  localparam bit SwitchEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SWITCH,
    SETUP,
    STEP,
    WAIT_LO,
    WAIT_HI
  } state_e;

  state_e state_q, state_d;

  logic [DivW-1:0]  divCnt_q;
  logic             scanclk_q;
  logic [7:0]       targetPhase_q, targetPhase_d;
  logic             pendValid_q, pendValid_d;
  logic             pendSrc_q, pendSrc_d;
  logic [7:0]       pendPhase_q, pendPhase_d;
  logic [7:0]       curPhase_q, curPhase_d;
  logic             curSrc_q, curSrc_d;
  logic             phaseUpDown_q, phaseUpDown_d;
  logic             phaseStep_q, phaseStep_d;
  logic [1:0]       stepCnt_q, stepCnt_d;
  logic [SwW-1:0]   swCnt_q, swCnt_d;
  logic [WaitW-1:0] waitCnt_q, waitCnt_d;
  logic             timeoutErr_q, timeoutErr_d;

  logic             scanFall;
  logic             nextAvail;
  logic             nextSrc;
  logic [7:0]       nextPhase;
  logic             launch;

  // Free-running scan clock divider. scanclk starts low and first rises after
  // SCANCLK_DIV clk cycles; scanFall flags the clk edge on which it falls so
  // phasestep can be moved in lockstep with that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt_q  <= '0;
      scanclk_q <= 1'b0;
    end else if (divCnt_q == DivLast) begin
      divCnt_q  <= '0;
      scanclk_q <= ~scanclk_q;
    end else begin
      divCnt_q  <= divCnt_q + 1'b1;
    end
  end

  assign scanFall = scanclk_q && (divCnt_q == DivLast);

  // The next request to start is a strobe arriving this very cycle (newest)
  // or, failing that, whatever sits in the one-deep pending register.
  assign nextAvail = updatepll || pendValid_q;
  assign nextSrc   = updatepll ? pll_clk_src   : pendSrc_q;
  assign nextPhase = updatepll ? pll_clk_phase : pendPhase_q;

  // Control state register plus all datapath registers. Everything clears
  // asynchronously so phasestep and clkswitch drop the moment reset asserts
  // and both the running and the pending request are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      targetPhase_q <= '0;
      pendValid_q   <= 1'b0;
      pendSrc_q     <= 1'b0;
      pendPhase_q   <= '0;
      curPhase_q    <= '0;
      curSrc_q      <= 1'b0;
      phaseUpDown_q <= 1'b1;
      phaseStep_q   <= 1'b0;
      stepCnt_q     <= '0;
      swCnt_q       <= '0;
      waitCnt_q     <= '0;
      timeoutErr_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      targetPhase_q <= targetPhase_d;
      pendValid_q   <= pendValid_d;
      pendSrc_q     <= pendSrc_d;
      pendPhase_q   <= pendPhase_d;
      curPhase_q    <= curPhase_d;
      curSrc_q      <= curSrc_d;
      phaseUpDown_q <= phaseUpDown_d;
      phaseStep_q   <= phaseStep_d;
      stepCnt_q     <= stepCnt_d;
      swCnt_q       <= swCnt_d;
      waitCnt_q     <= waitCnt_d;
      timeoutErr_q  <= timeoutErr_d;
    end
  end

  // Next-state logic. A strobe seen outside IDLE always lands in the pending
  // register first; the IDLE and SETUP-complete branches then consume it
  // directly so a queued request starts without a detour through IDLE.
  // STEP counts scanclk falling edges: the first two give phaseupdown a full
  // scanclk period to settle, phasestep rises on the second and falls two
  // falling edges later, which spans exactly two scanclk rising edges.
  always_comb begin
    state_d       = state_q;
    targetPhase_d = targetPhase_q;
    pendValid_d   = pendValid_q;
    pendSrc_d     = pendSrc_q;
    pendPhase_d   = pendPhase_q;
    curPhase_d    = curPhase_q;
    curSrc_d      = curSrc_q;
    phaseUpDown_d = phaseUpDown_q;
    phaseStep_d   = phaseStep_q;
    stepCnt_d     = stepCnt_q;
    swCnt_d       = swCnt_q;
    waitCnt_d     = waitCnt_q;
    timeoutErr_d  = timeoutErr_q;
    launch        = 1'b0;

    if (updatepll && (state_q != IDLE)) begin
      pendValid_d = 1'b1;
      pendSrc_d   = pll_clk_src;
      pendPhase_d = pll_clk_phase;
    end

    unique case (state_q)
      IDLE: begin
        if (nextAvail) begin
          launch      = 1'b1;
          pendValid_d = 1'b0;
        end
      end

      SWITCH: begin
        if (swCnt_q == SwLast) begin
          swCnt_d  = '0;
          curSrc_d = ~curSrc_q;
          state_d  = SETUP;
        end else begin
          swCnt_d  = swCnt_q + 1'b1;
        end
      end

      SETUP: begin
        if (targetPhase_q == curPhase_q) begin
          if (nextAvail) begin
            launch      = 1'b1;
            pendValid_d = 1'b0;
          end else begin
            state_d     = IDLE;
          end
        end else begin
          phaseUpDown_d = (targetPhase_q > curPhase_q);
          stepCnt_d     = '0;
          state_d       = STEP;
        end
      end

      STEP: begin
        if (scanFall) begin
          unique case (stepCnt_q)
            2'd0: stepCnt_d = 2'd1;
            2'd1: begin
              stepCnt_d   = 2'd2;
              phaseStep_d = 1'b1;
            end
            2'd2: stepCnt_d = 2'd3;
            default: begin
              stepCnt_d   = 2'd0;
              phaseStep_d = 1'b0;
              waitCnt_d   = '0;
              state_d     = WAIT_LO;
            end
          endcase
        end
      end

      WAIT_LO: begin
        if (!phasedone) begin
          waitCnt_d    = '0;
          state_d      = WAIT_HI;
        end else if (waitCnt_q == WaitLast) begin
          waitCnt_d    = '0;
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end else begin
          waitCnt_d    = waitCnt_q + 1'b1;
        end
      end

      WAIT_HI: begin
        if (phasedone) begin
          waitCnt_d    = '0;
          curPhase_d   = phaseUpDown_q ? (curPhase_q + 8'd1) : (curPhase_q - 8'd1);
          state_d      = SETUP;
        end else if (waitCnt_q == WaitLast) begin
          waitCnt_d    = '0;
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end else begin
          waitCnt_d    = waitCnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (launch) begin
      targetPhase_d = nextPhase;
      if (SwitchEn && (nextSrc != curSrc_q)) begin
        swCnt_d = '0;
        state_d = SWITCH;
      end else begin
        state_d = SETUP;
      end
    end
  end

`ifdef PLL_CLKSWITCH_EN
  logic clkSwitch_q;

  // clkswitch comes straight from a flop so the PLL sees a glitch-free pulse
  // that is high for exactly the cycles spent in SWITCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkSwitch_q <= 1'b0;
    end else begin
      clkSwitch_q <= (state_d == SWITCH);
    end
  end

  assign clkswitch = clkSwitch_q;
`else
  assign clkswitch = 1'b0;
`endif

  assign scanclk            = scanclk_q;
  assign phasecounterselect = 3'b000;
  assign phaseupdown        = phaseUpDown_q;
  assign phasestep          = phaseStep_q;
  assign busy               = (state_q != IDLE) || pendValid_q;
  assign cur_phase          = curPhase_q;
  assign cur_src            = curSrc_q;
  assign timeout_err        = timeoutErr_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// ---------------------------------------------------------------------------
// TbPllPhaseCtrl (module tb_pll_phase_ctrl)
//
// Directed self-checking bench for pll_phase_ctrl with default parameters.
// A small PLL model answers each phasestep pulse: phasedone drops two
// cycles after phasestep falls and returns high six cycles later. Monitors
// count phasestep pulses and record any timing violations of the
// phasestep/scanclk/phaseupdown relationship; the main sequence checks them.
// Honours PLL_CLKSWITCH_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_pll_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       updatepll = 1'b0;
  logic       pll_clk_src = 1'b0;
  logic [7:0] pll_clk_phase = 8'd0;
  logic       phasedone = 1'b1;
  logic       scanclk;
  logic [2:0] phasecounterselect;
  logic       phaseupdown;
  logic       phasestep;
  logic       clkswitch;
  logic       busy;
  logic [7:0] cur_phase;
  logic       cur_src;
  logic       timeout_err;

  int total = 0;
  int bad = 0;

  logic modelEn = 1'b1;
  int   modelCnt = 0;
  logic modelPrev = 1'b0;

  int   pulses = 0;
  int   downPulses = 0;
  int   alignErr = 0;
  int   holdErr = 0;
  int   udErr = 0;
  int   riseCnt = 0;
  int   udAge = 1000;
  int   busyCycles = 0;
  int   swHigh = 0;
  int   maxPhase = 0;
  logic psPrev = 1'b0;
  logic scPrev = 1'b0;
  logic udPrev = 1'b1;

  pll_phase_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .updatepll          (updatepll),
    .pll_clk_src        (pll_clk_src),
    .pll_clk_phase      (pll_clk_phase),
    .phasedone          (phasedone),
    .scanclk            (scanclk),
    .phasecounterselect (phasecounterselect),
    .phaseupdown        (phaseupdown),
    .phasestep          (phasestep),
    .clkswitch          (clkswitch),
    .busy               (busy),
    .cur_phase          (cur_phase),
    .cur_src            (cur_src),
    .timeout_err        (timeout_err)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // PLL model: after each phasestep falling edge, phasedone goes low two
  // cycles later and back high six cycles after that. Disabled, it holds
  // phasedone high forever so the controller must time out.
  always @(negedge clk) begin
    if (!rst_n || !modelEn) begin
      phasedone = 1'b1;
      modelCnt  = 0;
    end else begin
      if (modelPrev && !phasestep) begin
        modelCnt = 1;
      end else if (modelCnt > 0) begin
        modelCnt++;
      end
      if (modelCnt == 3) phasedone = 1'b0;
      if (modelCnt == 9) begin
        phasedone = 1'b1;
        modelCnt  = 0;
      end
    end
    modelPrev = phasestep;
  end

  // Protocol monitor: counts pulses and directions, and flags a phasestep
  // edge not aligned with a scanclk fall, a pulse not spanning exactly two
  // scanclk rises, or phaseupdown changing less than a scanclk period before
  // phasestep rises. Also accumulates busy and clkswitch high cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (phasestep && !psPrev) begin
        pulses++;
        if (!phaseupdown) downPulses++;
        if (!(scPrev && !scanclk)) alignErr++;
        if (udAge < 8) udErr++;
        riseCnt = 0;
      end
      if (!phasestep && psPrev) begin
        if (!(scPrev && !scanclk)) alignErr++;
        if (riseCnt != 2) holdErr++;
      end
      if (phasestep && !scPrev && scanclk) riseCnt++;
      if (busy) busyCycles++;
      if (clkswitch) swHigh++;
      if (int'(cur_phase) > maxPhase) maxPhase = int'(cur_phase);
    end
    if (phaseupdown !== udPrev) udAge = 0;
    else udAge++;
    udPrev = phaseupdown;
    psPrev = phasestep;
    scPrev = scanclk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic src, input logic [7:0] phase);
    tick();
    updatepll     = 1'b1;
    pll_clk_src   = src;
    pll_clk_phase = phase;
    tick();
    updatepll     = 1'b0;
  endtask

  task automatic doReset();
    tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, busy, 0);
  endtask

  task automatic waitStepHigh(input int budget, input string tag);
    int n = 0;
    while (!phasestep && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, phasestep, 1);
  endtask

  initial begin
    int n;
    int p0;
    int d0;
    int b0;
    int s0;

    $display("[TB] start");

    // Reset values and scanclk start-up timing.
    doReset();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cur_phase", cur_phase, 0);
    checkOutput("rst_cur_src", cur_src, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_phasestep", phasestep, 0);
    checkOutput("rst_clkswitch", clkswitch, 0);
    checkOutput("rst_phaseupdown", phaseupdown, 1);
    checkOutput("rst_pcs", phasecounterselect, 0);
    checkOutput("rst_scanclk", scanclk, 0);
    n = 0;
    while (!scanclk && n < 20) begin
      tick();
      n++;
    end
    checkOutput("scanclk_first_rise", n, 4);
    n = 0;
    while (scanclk && n < 20) begin
      tick();
      n++;
    end
    checkOutput("scanclk_high_len", n, 4);

    // Three up steps from phase 0.
    p0 = pulses;
    d0 = downPulses;
    applyStimulus(1'b0, 8'd3);
    checkOutput("busy_next_cycle", busy, 1);
    waitIdle(2000, "up3_idle");
    checkOutput("up3_pulses", pulses - p0, 3);
    checkOutput("up3_down_pulses", downPulses - d0, 0);
    checkOutput("up3_updown", phaseupdown, 1);
    checkOutput("up3_cur_phase", cur_phase, 3);

    // Two down steps, then a request that needs no work.
    p0 = pulses;
    d0 = downPulses;
    applyStimulus(1'b0, 8'd1);
    waitIdle(2000, "down2_idle");
    checkOutput("down2_pulses", pulses - p0, 2);
    checkOutput("down2_down_pulses", downPulses - d0, 2);
    checkOutput("down2_updown", phaseupdown, 0);
    checkOutput("down2_cur_phase", cur_phase, 1);
    p0 = pulses;
    b0 = busyCycles;
    applyStimulus(1'b0, 8'd1);
    waitIdle(50, "same_idle");
    repeat (3) tick();
    checkOutput("same_pulses", pulses - p0, 0);
    checkOutput("same_busy_le2", ((busyCycles - b0) >= 1) && ((busyCycles - b0) <= 2), 1);
    checkOutput("same_cur_phase", cur_phase, 1);

    // Clock source switch request from reset.
    doReset();
    p0 = pulses;
    s0 = swHigh;
    applyStimulus(1'b1, 8'd0);
    waitIdle(200, "switch_idle");
    repeat (3) tick();
    checkOutput("switch_pulses", pulses - p0, 0);
`ifdef PLL_CLKSWITCH_EN
    checkOutput("switch_high_cycles", swHigh - s0, 8);
    checkOutput("switch_cur_src", cur_src, 1);
`else
    checkOutput("switch_high_cycles", swHigh - s0, 0);
    checkOutput("switch_cur_src", cur_src, 0);
`endif

    // phasedone never drops: timeout in WAIT_LO after 1024 cycles.
    doReset();
    modelEn = 1'b0;
    p0 = pulses;
    applyStimulus(1'b0, 8'd1);
    waitStepHigh(200, "to_step_high");
    n = 0;
    while (phasestep && n < 100) begin
      tick();
      n++;
    end
    checkOutput("to_step_low", phasestep, 0);
    n = 0;
    while (!timeout_err && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("timeout_latency", n, 1024);
    checkOutput("timeout_err", timeout_err, 1);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_cur_phase", cur_phase, 0);
    checkOutput("timeout_pulses", pulses - p0, 1);
    modelEn = 1'b1;
    repeat (2) tick();

    // Queued requests: phase 9 is overwritten by phase 2 before it runs.
    p0 = pulses;
    d0 = downPulses;
    applyStimulus(1'b0, 8'd5);
    waitStepHigh(200, "queue_first_step");
    applyStimulus(1'b0, 8'd9);
    applyStimulus(1'b0, 8'd2);
    waitIdle(3000, "queue_idle");
    checkOutput("queue_cur_phase", cur_phase, 2);
    checkOutput("queue_max_phase", maxPhase, 5);
    checkOutput("queue_pulses", pulses - p0, 8);
    checkOutput("queue_down_pulses", downPulses - d0, 3);
    checkOutput("timeout_sticky", timeout_err, 1);

    // Reset asserted while phasestep is high.
    applyStimulus(1'b0, 8'd4);
    waitStepHigh(200, "rstmid_step_high");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_phasestep_async", phasestep, 0);
    checkOutput("rstmid_clkswitch_async", clkswitch, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    checkOutput("rstmid_cur_phase", cur_phase, 0);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_timeout_cleared", timeout_err, 0);
    p0 = pulses;
    repeat (300) tick();
    checkOutput("rstmid_no_pulses", pulses - p0, 0);
    checkOutput("rstmid_still_idle", busy, 0);

    // Protocol timing seen by the monitor across the whole run.
    checkOutput("align_errors", alignErr, 0);
    checkOutput("hold_errors", holdErr, 0);
    checkOutput("updown_setup_errors", udErr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
